cacheline_arbiter: RTL and testbench

- Shares the single LLC-side port of the cacheline adaptor between the instruction cache (read-only) and the data cache (read/write).
- Grants one whole cacheline transaction at a time and registers the address, write data and command on grant.
- Returns the adaptor's response to the granted requester only.
- Sits between the two L1 caches and the cacheline adaptor.

---
 rtl/cacheline_arbiter.sv | 115 +++++++++++
 tb/tb_cacheline_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline-adaptor port between the I-cache and D-cache.
// One whole line transaction is granted at a time; the command, address and write data are registered on grant.
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic              m_read_o,
    output logic              m_write_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic [LINE_W-1:0] m_line_o,
    input  logic [LINE_W-1:0] m_line_i,
    input  logic              m_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_last_d;
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_address;
    logic [LINE_W-1:0] r_line;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;

    // Request decode; on a tie the side that was not granted last wins
    always_comb begin
        w_req_i = i_read_i;
        w_req_d = d_read_i | d_write_i;
        if (w_req_i && w_req_d) begin
            w_pick_d = ~r_last_d;
        end else begin
            w_pick_d = w_req_d;
        end
    end

    // Arbitration FSM with registered adaptor-side command, address and data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_address <= {ADDR_W{1'b0}};
            r_line    <= {LINE_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state   <= SERVE_D;
                        r_last_d  <= 1'b1;
                        r_address <= d_address_i;
                        r_line    <= d_line_i;
                        r_write   <= d_write_i;
                        r_read    <= ~d_write_i;
                    end else if (w_req_i) begin
                        r_state   <= SERVE_I;
                        r_last_d  <= 1'b0;
                        r_address <= i_address_i;
                        r_write   <= 1'b0;
                        r_read    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (m_resp_i) begin
                        r_state <= RELEASE;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    // Completion is steered combinationally to the granted requester only
    always_comb begin
        m_read_o    = r_read;
        m_write_o   = r_write;
        m_address_o = r_address;
        m_line_o    = r_line;
        i_line_o    = m_line_i;
        d_line_o    = m_line_i;
        i_resp_o    = (r_state == SERVE_I) && m_resp_i;
        d_resp_o    = (r_state == SERVE_D) && m_resp_i;
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: grant-vector table, directed corner sequences,
// and randomized traffic scored against a transaction-level round-robin model.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read_i;
    logic [31:0]  i_address_i;
    logic [255:0] i_line_o;
    logic         i_resp_o;
    logic         d_read_i;
    logic         d_write_i;
    logic [31:0]  d_address_i;
    logic [255:0] d_line_i;
    logic [255:0] d_line_o;
    logic         d_resp_o;
    logic         m_read_o;
    logic         m_write_o;
    logic [31:0]  m_address_o;
    logic [255:0] m_line_o;
    logic [255:0] m_line_i;
    logic         m_resp_i;

    int tests = 0;
    int fails = 0;

    cacheline_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_read_i(i_read_i), .i_address_i(i_address_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_address_i(d_address_i), .d_line_i(d_line_i),
        .d_line_o(d_line_o), .d_resp_o(d_resp_o),
        .m_read_o(m_read_o), .m_write_o(m_write_o), .m_address_o(m_address_o), .m_line_o(m_line_o),
        .m_line_i(m_line_i), .m_resp_i(m_resp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read_i = 1'b0; i_address_i = 32'h0;
        d_read_i = 1'b0; d_write_i = 1'b0; d_address_i = 32'h0; d_line_i = 256'h0;
        m_line_i = 256'h0; m_resp_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Hold the granted command for lat cycles, then answer and check the steering.
    task automatic complete(input logic exp_d, input int lat);
        logic [255:0] l;
        repeat (lat) begin
            tick();
            chk("no_early_resp", {i_resp_o, d_resp_o}, 2'b00);
            chk("cmd_held", m_read_o | m_write_o, 1'b1);
        end
        l = rand_line();
        m_line_i = l;
        m_resp_i = 1'b1;
        #1;
        chk("resp_i", i_resp_o, !exp_d);
        chk("resp_d", d_resp_o, exp_d);
        chk("line_back", exp_d ? d_line_o : i_line_o, l);
        tick();
        m_resp_i = 1'b0;
        chk("release_cmd", m_read_o | m_write_o, 1'b0);
    endtask

    task automatic wait_cmd(output int gap);
        gap = 0;
        while (!(m_read_o || m_write_o) && gap < 20) begin
            tick();
            gap++;
        end
        chk("cmd_seen", gap < 20, 1'b1);
    endtask

    typedef struct packed {
        logic         ir;
        logic         dr;
        logic         dw;
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [255:0] dl;
        logic         er;
        logic         ew;
        logic [31:0]  ea;
        logic [255:0] el;
    } vec_t;

    vec_t vt[7];

    logic [255:0] l1, l2, l3, lw;
    int           gap;

    // random-phase model state
    logic         ireq, dreq, act, gnt_d, last_d, prev_cmd, cmd, dropped;
    logic         exp_wr;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line, rl;
    int           cnt, idle, wi, wd, ntrans;

    initial begin
        reset = 1'b1;
        clear_inputs();
        l1 = {8{32'h1111_2222}};
        l2 = {8{32'hCAFE_F00D}};
        l3 = {8{32'h0BAD_BEEF}};
        //            ir    dr    dw    ia            da            dl  er    ew    ea            el
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, l1, 1'b1, 1'b0, 32'h0000_1000, 256'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h8000_0040, l1, 1'b1, 1'b0, 32'h8000_0040, l1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h8000_0080, l2, 1'b0, 1'b1, 32'h8000_0080, l2};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_00C0, l3, 1'b0, 1'b1, 32'h0000_00C0, l3};
        vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_4000, l1, 1'b1, 1'b0, 32'h0000_4000, l1};
        vt[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_4000, l1, 1'b0, 1'b0, 32'h0000_0000, 256'h0};
        vt[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_6000, l2, 1'b0, 1'b1, 32'h0000_6000, l2};

        // reset state
        do_reset();
        chk("rst_read", m_read_o, 1'b0);
        chk("rst_write", m_write_o, 1'b0);
        chk("rst_addr", m_address_o, 32'h0);
        chk("rst_line", m_line_o, 256'h0);
        chk("rst_resp", {i_resp_o, d_resp_o}, 2'b00);

        // first grant out of reset for each request pattern
        for (int v = 0; v < 7; v++) begin
            do_reset();
            i_read_i = vt[v].ir; d_read_i = vt[v].dr; d_write_i = vt[v].dw;
            i_address_i = vt[v].ia; d_address_i = vt[v].da; d_line_i = vt[v].dl;
            tick();
            chk("vec_read", m_read_o, vt[v].er);
            chk("vec_write", m_write_o, vt[v].ew);
            chk("vec_addr", m_address_o, vt[v].ea);
            chk("vec_line", m_line_o, vt[v].el);
        end

        // single I read answered after 5 cycles
        do_reset();
        i_read_i = 1'b1; i_address_i = 32'h0000_1000;
        tick();
        chk("t1_read", m_read_o, 1'b1);
        chk("t1_addr", m_address_o, 32'h0000_1000);
        complete(1'b0, 5);

        // D write; write data changes after grant and must not leak through
        do_reset();
        for (int b = 0; b < 32; b++) lw[b*8 +: 8] = b[7:0];
        d_write_i = 1'b1; d_address_i = 32'h8000_0040; d_line_i = lw;
        tick();
        repeat (3) begin
            d_line_i = ~d_line_i;
            d_address_i = d_address_i + 32'h40;
            chk("t2_write", m_write_o, 1'b1);
            chk("t2_read", m_read_o, 1'b0);
            chk("t2_line", m_line_o, lw);
            chk("t2_addr", m_address_o, 32'h8000_0040);
            tick();
        end
        complete(1'b1, 1);

        // held simultaneous reads alternate D, I, D, I
        do_reset();
        i_read_i = 1'b1; i_address_i = 32'h0000_AAA0;
        d_read_i = 1'b1; d_address_i = 32'h0000_DDD0;
        for (int k = 0; k < 4; k++) begin
            wait_cmd(gap);
            if (k > 0) chk("t3_gap", gap >= 2, 1'b1);
            chk("t3_addr", m_address_o, (k % 2 == 0) ? 32'h0000_DDD0 : 32'h0000_AAA0);
            complete(k % 2 == 0, 2);
        end

        // asynchronous reset in the middle of a D write
        do_reset();
        d_write_i = 1'b1; d_address_i = 32'h0000_0040; d_line_i = l3;
        tick();
        chk("t5_write_before", m_write_o, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_write_async", m_write_o, 1'b0);
        chk("t5_addr_async", m_address_o, 32'h0);
        #1;
        d_write_i = 1'b0;
        i_read_i = 1'b1; i_address_i = 32'h0000_0100;
        d_read_i = 1'b1; d_address_i = 32'h0000_0200;
        reset = 1'b0;
        tick();
        chk("t5_regrant_d", m_address_o, 32'h0000_0200);
        chk("t5_regrant_rd", m_read_o, 1'b1);

        // stray response in IDLE
        do_reset();
        m_resp_i = 1'b1; m_line_i = l1;
        #1;
        chk("t6_resp", {i_resp_o, d_resp_o}, 2'b00);
        tick();
        chk("t6_cmd", m_read_o | m_write_o, 1'b0);
        chk("t6_resp2", {i_resp_o, d_resp_o}, 2'b00);
        m_resp_i = 1'b0;
        i_read_i = 1'b1; i_address_i = 32'h0000_0500;
        tick();
        chk("t6_idle_grant", m_read_o, 1'b1);

        // randomized traffic against a transaction-level model
        do_reset();
        ireq = 1'b0; dreq = 1'b0; act = 1'b0; gnt_d = 1'b0; last_d = 1'b0; prev_cmd = 1'b0;
        exp_wr = 1'b0; exp_addr = 32'h0; exp_line = 256'h0;
        cnt = 0; idle = 2; wi = 0; wd = 0; ntrans = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            cmd = m_read_o | m_write_o;
            if (idle >= 2 && !prev_cmd && (ireq || dreq)) chk("r_grant_when_idle", cmd, 1'b1);
            if (cmd && !prev_cmd) begin
                chk("r_grant_gap", idle >= 2, 1'b1);
                chk("r_grant_has_req", ireq | dreq, 1'b1);
                gnt_d    = (ireq && dreq) ? !last_d : dreq;
                last_d   = gnt_d;
                exp_addr = gnt_d ? d_address_i : i_address_i;
                exp_wr   = gnt_d ? d_write_i : 1'b0;
                exp_line = d_line_i;
                act = 1'b1;
                cnt = $urandom_range(0, 6);
                ntrans++;
            end
            if (cmd) begin
                idle = 0;
                chk("r_write", m_write_o, exp_wr);
                chk("r_read", m_read_o, !exp_wr);
                chk("r_addr", m_address_o, exp_addr);
                if (exp_wr) chk("r_line", m_line_o, exp_line);
            end else begin
                idle++;
                if (act) chk("r_cmd_held", cmd, 1'b1);
            end
            prev_cmd = cmd;
            dropped = 1'b0;
            m_resp_i = 1'b0;
            if (act && cnt == 0) begin
                rl = rand_line();
                m_line_i = rl;
                m_resp_i = 1'b1;
                #1;
                chk("r_resp_i", i_resp_o, !gnt_d);
                chk("r_resp_d", d_resp_o, gnt_d);
                chk("r_line_back", gnt_d ? d_line_o : i_line_o, rl);
                act = 1'b0;
                dropped = 1'b1;
                if (gnt_d) begin
                    dreq = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
                end else begin
                    ireq = 1'b0; i_read_i = 1'b0;
                end
            end else begin
                if (act) cnt--;
                else if ($urandom_range(0, 7) == 0) m_resp_i = 1'b1;
                #1;
                chk("r_no_resp", {i_resp_o, d_resp_o}, 2'b00);
            end
            if (act) begin
                if (gnt_d) begin
                    d_address_i = $urandom; d_line_i = rand_line();
                end else begin
                    i_address_i = $urandom;
                end
            end
            if (!ireq && !(dropped && !gnt_d) && $urandom_range(0, 3) == 0) begin
                ireq = 1'b1; i_read_i = 1'b1; i_address_i = $urandom;
            end
            if (!dreq && !(dropped && gnt_d) && $urandom_range(0, 3) == 0) begin
                dreq = 1'b1;
                {d_write_i, d_read_i} = 2'($urandom_range(1, 3));
                d_address_i = $urandom; d_line_i = rand_line();
            end
            wi = (ireq && !(act && !gnt_d)) ? wi + 1 : 0;
            wd = (dreq && !(act && gnt_d)) ? wd + 1 : 0;
            if (wi > 40 || wd > 40) begin
                chk("r_starvation", 1'b1, 1'b0);
                wi = 0; wd = 0;
            end
        end
        chk("r_some_traffic", ntrans > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
